// File: rtl/sar_adc_ctrl.sv
// ---------------------------------------------------------------------------
// sar_adc_ctrl
// Successive-approximation ADC controller. It samples the input on the
// track/hold switch, then resolves one bit per trial, MSB first, by
// driving a trial code into the SAR DAC and reading back the external
// comparator through a two-flop synchronizer.
//
// Ports
//   CLK        system clock (PLL output)
//   reset      asynchronous, active-low reset
//   START      conversion request, level-sampled only while idle
//   CMP        asynchronous comparator, 1 = Vin >= Vdac(DAC_CODE)
//   SAMPLE_EN  track/hold control, 1 = tracking
//   DAC_CODE   trial code to the SAR DAC (holds the result after a conversion)
//   DATA       last completed conversion result
//   VALID      one-cycle strobe, DATA newly updated
//   BUSY       conversion in progress
// All outputs are registered; no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module sar_adc_ctrl #(
    parameter int WIDTH         = 10,
    parameter int SAMPLE_CYCLES = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             START,
    input  logic             CMP,
    output logic             SAMPLE_EN,
    output logic [WIDTH-1:0] DAC_CODE,
    output logic [WIDTH-1:0] DATA,
    output logic             VALID,
    output logic             BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAMPLE  = 2'd1,
        ST_CONVERT = 2'd2
    } state_t;

    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SMP_W = $clog2(SAMPLE_CYCLES + 1);
    localparam int STL_W = $clog2(SETTLE_CYCLES);

    // Sample counter counts down from SAMPLE_CYCLES-1 so that the SAMPLE
    // state spans exactly SAMPLE_CYCLES edges.
    localparam logic [SMP_W-1:0] SMP_LOAD = SMP_W'(SAMPLE_CYCLES - 1);
    localparam logic [SMP_W-1:0] SMP_ZERO = {SMP_W{1'b0}};
    localparam logic [SMP_W-1:0] SMP_ONE  = SMP_W'(1'b1);
    localparam logic [STL_W-1:0] STL_LAST = STL_W'(SETTLE_CYCLES - 1);
    localparam logic [STL_W-1:0] STL_ZERO = {STL_W{1'b0}};
    localparam logic [STL_W-1:0] STL_ONE  = STL_W'(1'b1);
    localparam logic [BIT_W-1:0] BIT_MSB  = BIT_W'(WIDTH - 1);
    localparam logic [BIT_W-1:0] BIT_ZERO = {BIT_W{1'b0}};
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1'b1);
    localparam logic [WIDTH-1:0] CODE_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CODE_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CODE_MSB  = CODE_ONE << (WIDTH - 1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [1:0]         cmp_sync_r;
    logic               cmp_s;
    logic [SMP_W-1:0]   smp_cnt_r;
    logic [SMP_W-1:0]   smp_cnt_nxt_s;
    logic [STL_W-1:0]   stl_cnt_r;
    logic [STL_W-1:0]   stl_cnt_nxt_s;
    logic [BIT_W-1:0]   bit_idx_r;
    logic [BIT_W-1:0]   bit_idx_nxt_s;
    logic               sample_en_nxt_s;
    logic               busy_nxt_s;
    logic               valid_nxt_s;
    logic [WIDTH-1:0]   dac_nxt_s;
    logic [WIDTH-1:0]   data_nxt_s;
    logic               smp_done_s;
    logic               trial_done_s;
    logic               last_trial_s;
    logic [WIDTH-1:0]   bit_mask_s;
    logic [WIDTH-1:0]   resolved_s;

    assign cmp_s = cmp_sync_r[1];

    assign smp_done_s   = (state_r == ST_SAMPLE) && (smp_cnt_r == SMP_ZERO);
    assign trial_done_s = (state_r == ST_CONVERT) && (stl_cnt_r == STL_LAST);
    assign last_trial_s = trial_done_s && (bit_idx_r == BIT_ZERO);

    // Decision for the bit under trial: drop it when the comparator says
    // Vin < Vdac, and in the same update raise the next-lower bit (the
    // shifted mask is zero once bit 0 is being resolved).
    assign bit_mask_s = CODE_ONE << bit_idx_r;
    assign resolved_s = (cmp_s ? DAC_CODE : (DAC_CODE & ~bit_mask_s)) | (bit_mask_s >> 1);

    // Two-flop synchronizer for the asynchronous comparator input.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            cmp_sync_r <= 2'b00;
        end else begin
            cmp_sync_r <= {cmp_sync_r[0], CMP};
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (START) begin
                    state_nxt_s = ST_SAMPLE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SAMPLE: begin
                if (smp_done_s) begin
                    state_nxt_s = ST_CONVERT;
                end else begin
                    state_nxt_s = ST_SAMPLE;
                end
            end
            ST_CONVERT: begin
                if (last_trial_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CONVERT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM output logic: next values of the registered outputs and counters.
    always_comb begin
        sample_en_nxt_s = SAMPLE_EN;
        busy_nxt_s      = BUSY;
        valid_nxt_s     = 1'b0;
        dac_nxt_s       = DAC_CODE;
        data_nxt_s      = DATA;
        smp_cnt_nxt_s   = smp_cnt_r;
        stl_cnt_nxt_s   = stl_cnt_r;
        bit_idx_nxt_s   = bit_idx_r;
        case (state_r)
            ST_IDLE: begin
                if (START) begin
                    sample_en_nxt_s = 1'b1;
                    busy_nxt_s      = 1'b1;
                    dac_nxt_s       = CODE_ZERO;
                    smp_cnt_nxt_s   = SMP_LOAD;
                end else begin
                    busy_nxt_s      = 1'b0;
                end
            end
            ST_SAMPLE: begin
                if (smp_done_s) begin
                    sample_en_nxt_s = 1'b0;
                    dac_nxt_s       = CODE_MSB;
                    bit_idx_nxt_s   = BIT_MSB;
                    stl_cnt_nxt_s   = STL_ZERO;
                end else begin
                    smp_cnt_nxt_s   = smp_cnt_r - SMP_ONE;
                end
            end
            ST_CONVERT: begin
                if (trial_done_s) begin
                    dac_nxt_s     = resolved_s;
                    stl_cnt_nxt_s = STL_ZERO;
                    if (bit_idx_r == BIT_ZERO) begin
                        data_nxt_s  = resolved_s;
                        valid_nxt_s = 1'b1;
                        busy_nxt_s  = 1'b0;
                    end else begin
                        bit_idx_nxt_s = bit_idx_r - BIT_ONE;
                    end
                end else begin
                    stl_cnt_nxt_s = stl_cnt_r + STL_ONE;
                end
            end
            default: begin
                sample_en_nxt_s = 1'b0;
                busy_nxt_s      = 1'b0;
            end
        endcase
    end

    // Output and counter registers.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            SAMPLE_EN <= 1'b0;
            BUSY      <= 1'b0;
            VALID     <= 1'b0;
            DAC_CODE  <= CODE_ZERO;
            DATA      <= CODE_ZERO;
            smp_cnt_r <= SMP_ZERO;
            stl_cnt_r <= STL_ZERO;
            bit_idx_r <= BIT_ZERO;
        end else begin
            SAMPLE_EN <= sample_en_nxt_s;
            BUSY      <= busy_nxt_s;
            VALID     <= valid_nxt_s;
            DAC_CODE  <= dac_nxt_s;
            DATA      <= data_nxt_s;
            smp_cnt_r <= smp_cnt_nxt_s;
            stl_cnt_r <= stl_cnt_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
        end
    end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sar_adc_ctrl
// Self-checking bench for sar_adc_ctrl with default parameters. An ideal
// comparator CMP = (DAC_CODE <= vin_code) closes the loop, with an override
// for injecting asynchronous glitches. Expected results are queued when a
// conversion is started and compared when VALID is observed.
// ---------------------------------------------------------------------------
module tb_sar_adc_ctrl;

    localparam int W   = 10;
    localparam int LAT = 42;   // SAMPLE_CYCLES + WIDTH*SETTLE_CYCLES

    typedef struct {
        logic [W-1:0] vin;
        logic [W-1:0] exp_data;
    } vec_t;

    logic         CLK;
    logic         reset;
    logic         START;
    logic         CMP;
    logic         SAMPLE_EN;
    logic [W-1:0] DAC_CODE;
    logic [W-1:0] DATA;
    logic         VALID;
    logic         BUSY;

    logic [W-1:0] vin_code;
    logic         cmp_ovr_en;
    logic         cmp_ovr;

    int           checks = 0;
    int           errors = 0;
    int           pos_cnt = 0;
    int           valid_cnt = 0;
    int           vd_pos = 0;
    logic [W-1:0] vd_data = '0;
    logic [W-1:0] vd_dac = '0;
    logic         vd_busy = 1'b0;
    logic [W-1:0] exp_q[$];
    vec_t         tbl[8];

    assign CMP = cmp_ovr_en ? cmp_ovr : (DAC_CODE <= vin_code);

    sar_adc_ctrl dut (
        .CLK       (CLK),
        .reset     (reset),
        .START     (START),
        .CMP       (CMP),
        .SAMPLE_EN (SAMPLE_EN),
        .DAC_CODE  (DAC_CODE),
        .DATA      (DATA),
        .VALID     (VALID),
        .BUSY      (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) pos_cnt <= pos_cnt + 1;

    // Records every VALID strobe, sampled on the falling edge.
    always @(negedge CLK) begin
        if (VALID) begin
            valid_cnt <= valid_cnt + 1;
            vd_data   <= DATA;
            vd_dac    <= DAC_CODE;
            vd_busy   <= BUSY;
            vd_pos    <= pos_cnt;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic start_conv(input logic [W-1:0] vin, input logic [W-1:0] expd,
                              output int v0, output int e0);
        vin_code = vin;
        v0 = valid_cnt;
        exp_q.push_back(expd);
        START = 1'b1;
        e0 = pos_cnt + 1;
        tick();
        START = 1'b0;
    endtask

    task automatic wait_pop(input string nm, input int v0);
        int n;
        logic [W-1:0] e;
        n = 0;
        while (valid_cnt == v0 && n < 200) begin
            tick();
            n++;
        end
        e = exp_q.pop_front();
        chk({nm, ".valid_seen"}, valid_cnt - v0, 1);
        if (valid_cnt != v0) begin
            chk({nm, ".data"}, int'(vd_data), int'(e));
            chk({nm, ".dac_hold"}, int'(vd_dac), int'(e));
            chk({nm, ".busy"}, int'(vd_busy), 0);
        end
    endtask

    task automatic finish_conv(input string nm, input int v0, input int e0);
        wait_pop(nm, v0);
        chk({nm, ".latency"}, vd_pos - e0, LAT);
        repeat (3) tick();
        chk({nm, ".one_valid"}, valid_cnt - v0, 1);
        chk({nm, ".dac_after"}, int'(DAC_CODE), int'(DATA));
    endtask

    task automatic conv(input logic [W-1:0] vin, input logic [W-1:0] expd, input string nm);
        int v0, e0;
        start_conv(vin, expd, v0, e0);
        finish_conv(nm, v0, e0);
    endtask

    initial begin
        int v0, e0, prev;
        logic [W-1:0] r;

        tbl[0] = '{vin: 10'h2A5, exp_data: 10'h2A5};
        tbl[1] = '{vin: 10'h3FF, exp_data: 10'h3FF};
        tbl[2] = '{vin: 10'h000, exp_data: 10'h000};
        tbl[3] = '{vin: 10'h0F0, exp_data: 10'h0F0};
        tbl[4] = '{vin: 10'h001, exp_data: 10'h001};
        tbl[5] = '{vin: 10'h200, exp_data: 10'h200};
        tbl[6] = '{vin: 10'h1FF, exp_data: 10'h1FF};
        tbl[7] = '{vin: 10'h3FE, exp_data: 10'h3FE};

        reset = 1'b0;
        START = 1'b0;
        vin_code = 10'h000;
        cmp_ovr_en = 1'b0;
        cmp_ovr = 1'b0;
        repeat (3) tick();
        chk("rst.sample_en", int'(SAMPLE_EN), 0);
        chk("rst.dac", int'(DAC_CODE), 0);
        chk("rst.data", int'(DATA), 0);
        chk("rst.valid", int'(VALID), 0);
        chk("rst.busy", int'(BUSY), 0);
        reset = 1'b1;
        repeat (2) tick();

        // Detailed walk through the first trials of 0x2A5.
        start_conv(10'h2A5, 10'h2A5, v0, e0);
        chk("seq.e0_sample_en", int'(SAMPLE_EN), 1);
        chk("seq.e0_busy", int'(BUSY), 1);
        chk("seq.e0_dac", int'(DAC_CODE), 0);
        tick();
        chk("seq.e1_sample_en", int'(SAMPLE_EN), 1);
        tick();
        chk("seq.e2_sample_en", int'(SAMPLE_EN), 0);
        chk("seq.e2_dac", int'(DAC_CODE), 10'h200);
        repeat (3) tick();
        chk("seq.e5_dac", int'(DAC_CODE), 10'h200);
        tick();
        chk("seq.e6_dac", int'(DAC_CODE), 10'h300);
        repeat (4) tick();
        chk("seq.e10_dac", int'(DAC_CODE), 10'h280);
        chk("seq.e10_busy", int'(BUSY), 1);
        finish_conv("seq", v0, e0);

        // Table-driven conversions.
        for (int i = 0; i < 8; i++) begin
            conv(tbl[i].vin, tbl[i].exp_data, $sformatf("tbl%0d", i));
        end

        // START held high: back-to-back conversions every LAT+1 cycles.
        vin_code = 10'h155;
        v0 = valid_cnt;
        prev = 0;
        START = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(10'h155);
            wait_pop($sformatf("b2b%0d", k), v0 + k);
            if (k > 0) begin
                chk($sformatf("b2b%0d.period", k), vd_pos - prev, LAT + 1);
            end
            prev = vd_pos;
        end
        START = 1'b0;
        exp_q.push_back(10'h155);
        wait_pop("b2b_tail", v0 + 3);
        repeat (3) tick();

        // START pulsed during CONVERT is ignored.
        start_conv(10'h0AA, 10'h0AA, v0, e0);
        repeat (10) tick();
        START = 1'b1;
        tick();
        START = 1'b0;
        finish_conv("ign", v0, e0);

        // Asynchronous reset during the bit-5 trial.
        start_conv(10'h3C3, 10'h3C3, v0, e0);
        repeat (20) tick();
        #3;
        reset = 1'b0;
        #1;
        chk("arst.sample_en", int'(SAMPLE_EN), 0);
        chk("arst.dac", int'(DAC_CODE), 0);
        chk("arst.data", int'(DATA), 0);
        chk("arst.valid", int'(VALID), 0);
        chk("arst.busy", int'(BUSY), 0);
        exp_q.delete();
        repeat (3) tick();
        chk("arst.no_valid", valid_cnt - v0, 0);
        reset = 1'b1;
        tick();
        conv(10'h0F0, 10'h0F0, "arst_after");

        // Glitching comparator during the bit-9 trial, settled at 0 before
        // the sampling window: bit 9 must be dropped.
        start_conv(10'h2A5, 10'h1FF, v0, e0);
        tick();
        tick();
        cmp_ovr_en = 1'b1;
        cmp_ovr = 1'b1;
        #2 cmp_ovr = 1'b0;
        #2 cmp_ovr = 1'b1;
        #2 cmp_ovr = 1'b0;
        repeat (4) tick();
        cmp_ovr_en = 1'b0;
        finish_conv("glitch", v0, e0);

        // Random sweep.
        for (int i = 0; i < 200; i++) begin
            r = W'($urandom_range(0, 1023));
            conv(r, r, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
